// File: rtl/load_store_unit_if.sv
// Bundles the core request/response handshake and the DataMemory bus.
// The slave modport is the load/store unit's view; master is the
// environment (core plus memory) driving requests and DataRd.
interface load_store_unit_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic [31:0] Address;
   logic [31:0] DataWr;
   logic        DMWr;
   logic [2:0]  DMCtrl;
   logic [31:0] DataRd;

   modport slave (
      input  req_valid, req_we, req_funct3, req_addr, req_wdata, DataRd,
      output req_ready, resp_valid, resp_rdata, resp_err,
      output Address, DataWr, DMWr, DMCtrl
   );

   modport master (
      output req_valid, req_we, req_funct3, req_addr, req_wdata, DataRd,
      input  req_ready, resp_valid, resp_rdata, resp_err,
      input  Address, DataWr, DMWr, DMCtrl
   );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one request per handshake, drives DataMemory,
// splits misaligned H/W accesses into byte accesses and returns the result
// with a one-cycle response pulse. Memory-side outputs are registered so
// they hold their last driven value between accesses.
module load_store_unit #(
   parameter int unsigned ADDR_MAX         = 1023,
   parameter bit          ALLOW_MISALIGNED = 1'b1
) (
   input logic              clk,
   input logic              rst_n,
   load_store_unit_if.slave bus
);

   typedef enum logic [1:0] {IDLE, ACCESS, SPLIT, RESP} state_t;

   state_t      state_q, state_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic        we_q, we_d;
   logic [2:0]  f3_q, f3_d;
   logic [1:0]  idx_q, idx_d;
   logic [31:0] buf_q, buf_d;
   logic [31:0] rdata_q, rdata_d;
   logic        err_q, err_d;
   logic [31:0] Address_q, Address_d;
   logic [31:0] DataWr_q, DataWr_d;
   logic        DMWr_q, DMWr_d;
   logic [2:0]  DMCtrl_q, DMCtrl_d;

   // Request decode, evaluated on the incoming request while in IDLE
   logic [2:0]  req_size;
   logic [32:0] req_end;
   logic        req_misal, req_illegal, req_err;

   // Split-access helpers
   logic        split_last;
   logic [1:0]  idx_nx;
   logic [31:0] buf_cur;
   logic [31:0] ext;

   // Size, end address (33-bit to avoid wrap) and error classification
   always_comb begin
      case (bus.req_funct3[1:0])
         2'b00:   req_size = 3'd1;
         2'b01:   req_size = 3'd2;
         default: req_size = 3'd4;
      endcase
      req_end     = {1'b0, bus.req_addr} + {30'b0, req_size} - 33'd1;
      req_misal   = ((bus.req_funct3[1:0] == 2'b01) && bus.req_addr[0]) ||
                    ((bus.req_funct3[1:0] == 2'b10) && (bus.req_addr[1:0] != 2'b00));
      req_illegal = (bus.req_funct3 == 3'b011) || (bus.req_funct3 == 3'b110) ||
                    (bus.req_funct3 == 3'b111) || (bus.req_we && bus.req_funct3[2]);
      req_err     = req_illegal || (req_end > 33'(ADDR_MAX)) ||
                    (req_misal && !ALLOW_MISALIGNED);
   end

   // State register and datapath registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         addr_q    <= '0;
         wdata_q   <= '0;
         we_q      <= 1'b0;
         f3_q      <= '0;
         idx_q     <= '0;
         buf_q     <= '0;
         rdata_q   <= '0;
         err_q     <= 1'b0;
         Address_q <= '0;
         DataWr_q  <= '0;
         DMWr_q    <= 1'b0;
         DMCtrl_q  <= '0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         we_q      <= we_d;
         f3_q      <= f3_d;
         idx_q     <= idx_d;
         buf_q     <= buf_d;
         rdata_q   <= rdata_d;
         err_q     <= err_d;
         Address_q <= Address_d;
         DataWr_q  <= DataWr_d;
         DMWr_q    <= DMWr_d;
         DMCtrl_q  <= DMCtrl_d;
      end
   end

   // Next-state logic; memory outputs are set up one edge ahead of their cycle
   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      we_d      = we_q;
      f3_d      = f3_q;
      idx_d     = idx_q;
      buf_d     = buf_q;
      rdata_d   = rdata_q;
      err_d     = err_q;
      Address_d = Address_q;
      DataWr_d  = DataWr_q;
      DMWr_d    = 1'b0;
      DMCtrl_d  = DMCtrl_q;

      split_last = (f3_q[1:0] == 2'b01) ? (idx_q == 2'd1) : (idx_q == 2'd3);
      idx_nx     = idx_q + 2'd1;
      buf_cur    = buf_q;
      buf_cur[{idx_q, 3'b000} +: 8] = bus.DataRd[7:0];
      case (f3_q)
         3'b001:  ext = {{16{buf_cur[15]}}, buf_cur[15:0]};
         3'b101:  ext = {16'b0, buf_cur[15:0]};
         default: ext = buf_cur;
      endcase

      case (state_q)
         IDLE: begin
            if (bus.req_valid) begin
               addr_d  = bus.req_addr;
               wdata_d = bus.req_wdata;
               we_d    = bus.req_we;
               f3_d    = bus.req_funct3;
               idx_d   = '0;
               buf_d   = '0;
               rdata_d = '0;
               if (req_err) begin
                  err_d   = 1'b1;
                  state_d = RESP;
               end else begin
                  err_d     = 1'b0;
                  Address_d = bus.req_addr;
                  DMWr_d    = bus.req_we;
                  if (req_misal) begin
                     DMCtrl_d = bus.req_we ? 3'b000 : 3'b100;
                     DataWr_d = {24'b0, bus.req_wdata[7:0]};
                     state_d  = SPLIT;
                  end else begin
                     DMCtrl_d = bus.req_funct3;
                     DataWr_d = bus.req_wdata;
                     state_d  = ACCESS;
                  end
               end
            end
         end
         ACCESS: begin
            rdata_d = we_q ? '0 : bus.DataRd;
            state_d = RESP;
         end
         SPLIT: begin
            buf_d = buf_cur;
            if (split_last) begin
               rdata_d = we_q ? '0 : ext;
               state_d = RESP;
            end else begin
               idx_d     = idx_nx;
               Address_d = addr_q + {30'b0, idx_nx};
               DataWr_d  = {24'b0, wdata_q[{idx_nx, 3'b000} +: 8]};
               DMWr_d    = we_q;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign bus.req_ready  = rst_n && (state_q == IDLE);
   assign bus.resp_valid = (state_q == RESP);
   assign bus.resp_rdata = (state_q == RESP) ? rdata_q : '0;
   assign bus.resp_err   = (state_q == RESP) && err_q;
   assign bus.Address    = Address_q;
   assign bus.DataWr     = DataWr_q;
   assign bus.DMWr       = DMWr_q;
   assign bus.DMCtrl     = DMCtrl_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: byte-addressed DataMemory model, a table of
// directed requests with expected result/latency/write activity, and
// hand-written sequences for split write ordering and reset mid-split.
module tb_load_store_unit;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic mem_clr = 1'b1;
   always #5 clk = ~clk;

   load_store_unit_if bus();

   load_store_unit #(.ADDR_MAX(1023), .ALLOW_MISALIGNED(1'b1)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // DataMemory model: little-endian bytes, combinational extended read
   logic [7:0] mem [0:1023];
   logic [9:0] ma;
   always_comb begin
      ma = bus.Address[9:0];
      case (bus.DMCtrl)
         3'b000:  bus.DataRd = {{24{mem[ma][7]}}, mem[ma]};
         3'b100:  bus.DataRd = {24'b0, mem[ma]};
         3'b001:  bus.DataRd = {{16{mem[ma+10'd1][7]}}, mem[ma+10'd1], mem[ma]};
         3'b101:  bus.DataRd = {16'b0, mem[ma+10'd1], mem[ma]};
         default: bus.DataRd = {mem[ma+10'd3], mem[ma+10'd2], mem[ma+10'd1], mem[ma]};
      endcase
   end

   always @(posedge clk) begin
      if (mem_clr) begin
         for (int i = 0; i < 1024; i++) mem[i] <= 8'h00;
      end else if (bus.DMWr) begin
         mem[ma] <= bus.DataWr[7:0];
         if (bus.DMCtrl[1:0] != 2'b00) mem[ma+10'd1] <= bus.DataWr[15:8];
         if (bus.DMCtrl[1:0] == 2'b10) begin
            mem[ma+10'd2] <= bus.DataWr[23:16];
            mem[ma+10'd3] <= bus.DataWr[31:24];
         end
      end
   end

   typedef struct {
      logic        we;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rd;
      logic        exp_err;
      int          exp_lat;
      int          exp_nwr;
      logic        chk_wr;
      logic [31:0] exp_wa;
      logic [31:0] exp_wd;
      logic [2:0]  exp_wc;
   } vec_t;

   int n_checks = 0;
   int n_fail = 0;

   logic [31:0] wa [8];
   logic [31:0] wd [8];
   logic [2:0]  wc [8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [31:0] rd, input logic err,
                               input int lat, input int nwr, input logic cw,
                               input logic [31:0] wa0, input logic [31:0] wd0, input logic [2:0] wc0);
      vec_t v;
      v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata;
      v.exp_rd = rd; v.exp_err = err; v.exp_lat = lat; v.exp_nwr = nwr;
      v.chk_wr = cw; v.exp_wa = wa0; v.exp_wd = wd0; v.exp_wc = wc0;
      return v;
   endfunction

   // Issue one request and check response, latency and write activity
   task automatic run(input vec_t v, input string name);
      int lat;
      int nwr;
      bit got;
      logic [31:0] rd;
      logic err;
      @(negedge clk);
      chk({name, " ready"}, {31'b0, bus.req_ready}, 32'd1);
      bus.req_valid  = 1'b1;
      bus.req_we     = v.we;
      bus.req_funct3 = v.f3;
      bus.req_addr   = v.addr;
      bus.req_wdata  = v.wdata;
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      lat = 0; nwr = 0; got = 1'b0; rd = '0; err = 1'b0;
      while (!got && lat < 20) begin
         @(negedge clk);
         lat++;
         if (bus.DMWr) begin
            if (nwr < 8) begin
               wa[nwr] = bus.Address; wd[nwr] = bus.DataWr; wc[nwr] = bus.DMCtrl;
            end
            nwr++;
         end
         if (bus.resp_valid) begin
            got = 1'b1; rd = bus.resp_rdata; err = bus.resp_err;
         end
      end
      if (!got) $display("FAIL %s timeout: no resp_valid after %0d cycles", name, lat);
      chk({name, " latency"}, lat, v.exp_lat);
      chk({name, " rdata"}, rd, v.exp_rd);
      chk({name, " err"}, {31'b0, err}, {31'b0, v.exp_err});
      chk({name, " writes"}, nwr, v.exp_nwr);
      if (v.chk_wr && nwr > 0) begin
         chk({name, " wr0 addr"}, wa[0], v.exp_wa);
         chk({name, " wr0 data"}, wd[0], v.exp_wd);
         chk({name, " wr0 ctrl"}, {29'b0, wc[0]}, {29'b0, v.exp_wc});
      end
      @(negedge clk);
      chk({name, " resp pulse"}, {31'b0, bus.resp_valid}, 32'd0);
      chk({name, " ready after"}, {31'b0, bus.req_ready}, 32'd1);
   endtask

   task automatic chk_reset_outputs(input string name);
      chk({name, " resp_valid"}, {31'b0, bus.resp_valid}, 32'd0);
      chk({name, " resp_rdata"}, bus.resp_rdata, 32'd0);
      chk({name, " resp_err"}, {31'b0, bus.resp_err}, 32'd0);
      chk({name, " Address"}, bus.Address, 32'd0);
      chk({name, " DataWr"}, bus.DataWr, 32'd0);
      chk({name, " DMWr"}, {31'b0, bus.DMWr}, 32'd0);
      chk({name, " DMCtrl"}, {29'b0, bus.DMCtrl}, 32'd0);
   endtask

   vec_t vecs [26];

   initial begin
      bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = '0;
      bus.req_addr = '0; bus.req_wdata = '0;

      //        we  f3      addr        wdata         exp_rd        err lat nwr cw wa0       wd0           wc0
      vecs[0]  = mk(1, 3'b010, 32'h10,  32'hDEADBEEF, 32'h0,        0, 2, 1, 1, 32'h10,  32'hDEADBEEF, 3'b010);
      vecs[1]  = mk(0, 3'b010, 32'h10,  32'h0,        32'hDEADBEEF, 0, 2, 0, 0, 0, 0, 0);
      vecs[2]  = mk(1, 3'b000, 32'h0,   32'h57,       32'h0,        0, 2, 1, 1, 32'h0,   32'h57,       3'b000);
      vecs[3]  = mk(0, 3'b000, 32'h0,   32'h0,        32'h57,       0, 2, 0, 0, 0, 0, 0);
      vecs[4]  = mk(1, 3'b000, 32'h0,   32'h80,       32'h0,        0, 2, 1, 0, 0, 0, 0);
      vecs[5]  = mk(0, 3'b000, 32'h0,   32'h0,        32'hFFFFFF80, 0, 2, 0, 0, 0, 0, 0);
      vecs[6]  = mk(0, 3'b100, 32'h0,   32'h0,        32'h00000080, 0, 2, 0, 0, 0, 0, 0);
      vecs[7]  = mk(1, 3'b001, 32'h1,   32'h2B7F,     32'h0,        0, 3, 2, 1, 32'h1,   32'h7F,       3'b000);
      vecs[8]  = mk(0, 3'b001, 32'h1,   32'h0,        32'h00002B7F, 0, 3, 0, 0, 0, 0, 0);
      vecs[9]  = mk(1, 3'b001, 32'h1,   32'h8001,     32'h0,        0, 3, 2, 1, 32'h1,   32'h01,       3'b000);
      vecs[10] = mk(0, 3'b001, 32'h1,   32'h0,        32'hFFFF8001, 0, 3, 0, 0, 0, 0, 0);
      vecs[11] = mk(0, 3'b101, 32'h1,   32'h0,        32'h00008001, 0, 3, 0, 0, 0, 0, 0);
      vecs[12] = mk(1, 3'b010, 32'h10,  32'h11223344, 32'h0,        0, 2, 1, 0, 0, 0, 0);
      vecs[13] = mk(1, 3'b010, 32'h14,  32'h55667788, 32'h0,        0, 2, 1, 0, 0, 0, 0);
      vecs[14] = mk(0, 3'b010, 32'h13,  32'h0,        32'h66778811, 0, 5, 0, 0, 0, 0, 0);
      vecs[15] = mk(0, 3'b010, 32'd1021,32'h0,        32'h0,        1, 1, 0, 0, 0, 0, 0);
      vecs[16] = mk(0, 3'b011, 32'h0,   32'h0,        32'h0,        1, 1, 0, 0, 0, 0, 0);
      vecs[17] = mk(1, 3'b100, 32'h0,   32'hFF,       32'h0,        1, 1, 0, 0, 0, 0, 0);
      vecs[18] = mk(1, 3'b010, 32'd1020,32'hCAFEF00D, 32'h0,        0, 2, 1, 1, 32'd1020,32'hCAFEF00D, 3'b010);
      vecs[19] = mk(0, 3'b010, 32'd1020,32'h0,        32'hCAFEF00D, 0, 2, 0, 0, 0, 0, 0);
      vecs[20] = mk(0, 3'b001, 32'd1023,32'h0,        32'h0,        1, 1, 0, 0, 0, 0, 0);
      vecs[21] = mk(0, 3'b000, 32'd1023,32'h0,        32'hFFFFFFCA, 0, 2, 0, 0, 0, 0, 0);
      vecs[22] = mk(1, 3'b010, 32'h31,  32'hA1B2C3D4, 32'h0,        0, 5, 4, 1, 32'h31,  32'hD4,       3'b000);
      vecs[23] = mk(0, 3'b101, 32'h32,  32'h0,        32'h0000B2C3, 0, 2, 0, 0, 0, 0, 0);
      vecs[24] = mk(0, 3'b110, 32'h0,   32'h0,        32'h0,        1, 1, 0, 0, 0, 0, 0);
      vecs[25] = mk(1, 3'b101, 32'h2,   32'h1234,     32'h0,        1, 1, 0, 0, 0, 0, 0);

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst ready low", {31'b0, bus.req_ready}, 32'd0);
      chk_reset_outputs("rst");
      rst_n = 1'b1;
      mem_clr = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("rst ready high", {31'b0, bus.req_ready}, 32'd1);

      for (int i = 0; i < 26; i++) run(vecs[i], $sformatf("vec%0d", i));

      // Misaligned halfword store: both byte writes in order
      run(vecs[7], "sh_split");
      chk("sh_split wr1 addr", wa[1], 32'h2);
      chk("sh_split wr1 data", wd[1], 32'h2B);
      chk("sh_split wr1 ctrl", {29'b0, wc[1]}, 32'd0);

      // Misaligned word store aborted by reset after the second byte
      @(negedge clk);
      bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_funct3 = 3'b010;
      bus.req_addr = 32'h21; bus.req_wdata = 32'hAABBCCDD;
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      @(negedge clk);
      chk("abort b0 DMWr", {31'b0, bus.DMWr}, 32'd1);
      chk("abort b0 addr", bus.Address, 32'h21);
      @(negedge clk);
      chk("abort b1 DMWr", {31'b0, bus.DMWr}, 32'd1);
      chk("abort b1 data", bus.DataWr, 32'hCC);
      rst_n = 1'b0;
      @(negedge clk);
      chk("abort ready low", {31'b0, bus.req_ready}, 32'd0);
      chk_reset_outputs("abort");
      @(negedge clk);
      chk("abort resp_valid", {31'b0, bus.resp_valid}, 32'd0);
      rst_n = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("abort ready high", {31'b0, bus.req_ready}, 32'd1);
      chk("abort mem21", {24'b0, mem[10'h21]}, 32'hDD);
      chk("abort mem22", {24'b0, mem[10'h22]}, 32'hCC);
      chk("abort mem23", {24'b0, mem[10'h23]}, 32'h00);
      repeat (3) begin
         @(negedge clk);
         chk("abort no resp", {31'b0, bus.resp_valid}, 32'd0);
      end
      run(mk(0, 3'b000, 32'h22, 32'h0, 32'hFFFFFFCC, 0, 2, 0, 0, 0, 0, 0), "post_abort_lb");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Initiator side of the data-memory interface. Sits between the single-cycle core's execute stage and DataMemory.
- Accepts one load/store request per valid/ready handshake and drives Address/DataWr/DMWr/DMCtrl. Captures DataRd and returns the result with a one-cycle response pulse.
- Splits misaligned halfword/word accesses into sequential byte accesses. Flags illegal and out-of-range requests without touching memory.

Parameters:
ADDR_MAX, 1023, highest valid byte address of DataMemory
ALLOW_MISALIGNED, 1, 1 = split misaligned accesses into bytes; 0 = flag misaligned as error

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  synchronous active-low reset
req_valid  input  1  core request valid
req_ready  output  1  unit can accept a request (high only in IDLE)
req_we  input  1  1 = store, 0 = load
req_funct3  input  3  RISC-V width code: 000 B, 001 H, 010 W, 100 BU, 101 HU
req_addr  input  32  byte address
req_wdata  input  32  store data, LSB-aligned
resp_valid  output  1  one-cycle response pulse
resp_rdata  output  32  extended load data; 0 for stores and errors
resp_err  output  1  request rejected, valid with resp_valid
Address  output  32  DataMemory byte address
DataWr  output  32  DataMemory write data
DMWr  output  1  DataMemory write enable
DMCtrl  output  3  DataMemory width code (same encoding as req_funct3)
DataRd  input  32  DataMemory read data, combinational from Address/DMCtrl

Behaviour:
- Reset (rst_n=0 at an edge), from any state:
  - go to IDLE.
  - req_ready=0 while rst_n=0, then 1 in the first IDLE cycle.
  - resp_valid=0, resp_rdata=0, resp_err=0.
  - Address=0, DataWr=0, DMWr=0, DMCtrl=0.
- States: IDLE, ACCESS, SPLIT, RESP.
- IDLE:
  - req_ready=1. On req_valid, latch addr, we, funct3 and wdata.
  - Size = 1/2/4 bytes. Misaligned means H with addr[0]=1, or W with addr[1:0]!=0.
- Error check, at acceptance:
  - funct3 011/110/111 is an error.
  - Store with 100/101 is an error.
  - addr+size-1 > ADDR_MAX is an error.
  - Misaligned with ALLOW_MISALIGNED=0 is an error.
  - Error requests go to RESP with err=1. DMWr is never asserted for them.
- Aligned, no error: go to ACCESS.
- ACCESS, one cycle:
  - Address=addr, DMCtrl=funct3, DataWr=wdata, DMWr=we.
  - Load: DataRd is registered as-is (DataMemory extends) at the cycle end.
  - Next state: RESP.
- Misaligned, no error: go to SPLIT with byte counter i=0.
- SPLIT, one cycle per byte, i=0..size-1:
  - Address=addr+i.
  - DMCtrl=000 (store) or 100 (load).
  - DataWr={24'b0, wdata[8i+7:8i]}, DMWr=we.
  - Load: capture DataRd[7:0] into buffer byte i.
  - After i=size-1, go to RESP.
  - Extension on exit: H sign-extends from bit 15, HU zero-extends, W takes the buffer unchanged.
- RESP:
  - resp_valid=1 for exactly one cycle, with resp_rdata and resp_err.
  - No response backpressure. Next state: IDLE.
- Outside ACCESS/SPLIT:
  - DMWr=0.
  - Address/DataWr/DMCtrl hold their last driven values.
- Latency, with acceptance edge at cycle N:
  - aligned: memory cycle N+1, resp_valid N+2, req_ready N+3.
  - misaligned H: resp_valid N+3.
  - misaligned W: resp_valid N+5.
  - error: resp_valid N+1.
- Address arithmetic is 32-bit. The bounds check runs before any access, so addr+i never wraps past ADDR_MAX.
- Reset mid-SPLIT:
  - bytes already written stay in memory.
  - no resp_valid for the aborted request.
  - DMWr low from the cycle after the reset edge.
- req_valid while not in IDLE is ignored (req_ready=0).

Test Plan:
- SW 0xDEADBEEF @0x10, then LW @0x10 -> one DMWr cycle with DMCtrl=010, Address=0x10; LW resp_rdata=0xDEADBEEF, resp_valid at accept+2, resp_err=0.
- SB 0x57 @0, LB @0 -> 0x00000057. SB 0x80 @0, then LB -> 0xFFFFFF80 and LBU -> 0x00000080.
- SH 0x2B7F @1 -> two DMWr cycles: (Address=1, DataWr=0x7F, DMCtrl=000), then (Address=2, DataWr=0x2B). LH @1 -> 0x00002B7F. After SH 0x8001 @1: LH -> 0xFFFF8001, LHU -> 0x00008001.
- SW 0x11223344 @0x10, SW 0x55667788 @0x14, LW @0x13 -> four byte reads at 0x13..0x16, resp_rdata=0x66778811, resp_valid at accept+5.
- LW @1021 (ADDR_MAX=1023), funct3=011, and store with funct3=100 -> each gives resp_err=1, resp_rdata=0, resp_valid at accept+1, DMWr never high.
- SW misaligned @0x21, rst_n=0 after the 2nd byte -> DMWr=0 next cycle, no resp_valid, all outputs at reset values, req_ready=1 in the first cycle after rst_n returns high.
